// File: rtl/memory_cycle_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// The master holds req/we/addr/wdata steady until the slave answers with ack.
interface memory_cycle_if #(
   parameter int DW = 16
) ();
   logic          dmem_req;
   logic          dmem_we;
   logic [DW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/memory_cycle.sv
// Memory pipeline stage: passes ALU results straight to writeback, runs one
// data-memory access at a time with a bounded wait, and resolves branches.
module memory_cycle #(
   parameter int DW       = 16,
   parameter int RW       = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_valid,
   input  logic [DW-1:0] aluout,
   input  logic [DW-1:0] b,
   input  logic [RW-1:0] rd,
   input  logic [DW-1:0] newpc,
   input  logic          zero,
   input  logic          pos,
   input  logic          memread,
   input  logic          memwrite,
   input  logic          regwrite,
   input  logic [1:0]    branch,
   output logic          stall,
   memory_cycle_if.master dmem,
   output logic          wb_valid,
   output logic          wb_regwrite,
   output logic [RW-1:0] wb_rd,
   output logic [DW-1:0] wb_data,
   output logic          pc_src,
   output logic [DW-1:0] pc_target,
   output logic          mem_err
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   // Timeout fires on the edge that ends the MAX_WAIT-th WAIT cycle without ack.
   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   state_t        state_reg;
   logic          stall_reg;
   logic          dmem_req_reg;
   logic          dmem_we_reg;
   logic [DW-1:0] dmem_addr_reg;
   logic [DW-1:0] dmem_wdata_reg;
   logic          wb_valid_reg;
   logic          wb_regwrite_reg;
   logic [RW-1:0] wb_rd_reg;
   logic [DW-1:0] wb_data_reg;
   logic          pc_src_reg;
   logic [DW-1:0] pc_target_reg;
   logic          mem_err_reg;
   logic [7:0]    wait_cnt_reg;
   logic [RW-1:0] rd_hold_reg;
   logic          regwrite_hold_reg;
   logic          load_hold_reg;

   logic taken;
   logic is_mem;

   always_comb begin
      case (branch)
         2'b01:   taken = zero;
         2'b10:   taken = pos;
         2'b11:   taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   assign is_mem = memread | memwrite;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg         <= IDLE;
         stall_reg         <= 1'b0;
         dmem_req_reg      <= 1'b0;
         dmem_we_reg       <= 1'b0;
         dmem_addr_reg     <= '0;
         dmem_wdata_reg    <= '0;
         wb_valid_reg      <= 1'b0;
         wb_regwrite_reg   <= 1'b0;
         wb_rd_reg         <= '0;
         wb_data_reg       <= '0;
         pc_src_reg        <= 1'b0;
         pc_target_reg     <= '0;
         mem_err_reg       <= 1'b0;
         wait_cnt_reg      <= '0;
         rd_hold_reg       <= '0;
         regwrite_hold_reg <= 1'b0;
         load_hold_reg     <= 1'b0;
      end else begin
         wb_valid_reg <= 1'b0;
         pc_src_reg   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (ex_valid) begin
                  if (taken) begin
                     pc_src_reg    <= 1'b1;
                     pc_target_reg <= newpc;
                  end
                  if (is_mem) begin
                     state_reg         <= WAIT;
                     stall_reg         <= 1'b1;
                     dmem_req_reg      <= 1'b1;
                     dmem_we_reg       <= memwrite;
                     dmem_addr_reg     <= aluout;
                     dmem_wdata_reg    <= b;
                     rd_hold_reg       <= rd;
                     // read+write together is executed as a store with no register update
                     regwrite_hold_reg <= regwrite & ~(memread & memwrite);
                     load_hold_reg     <= memread & ~memwrite;
                     wait_cnt_reg      <= '0;
                  end else begin
                     wb_valid_reg    <= 1'b1;
                     wb_rd_reg       <= rd;
                     wb_data_reg     <= aluout;
                     wb_regwrite_reg <= regwrite;
                  end
               end
            end
            WAIT: begin
               if (dmem.dmem_ack) begin
                  state_reg       <= IDLE;
                  stall_reg       <= 1'b0;
                  dmem_req_reg    <= 1'b0;
                  wb_valid_reg    <= 1'b1;
                  wb_rd_reg       <= rd_hold_reg;
                  wb_regwrite_reg <= regwrite_hold_reg;
                  wb_data_reg     <= load_hold_reg ? dmem.dmem_rdata : dmem_addr_reg;
               end else if (wait_cnt_reg == LAST_WAIT) begin
                  state_reg       <= IDLE;
                  stall_reg       <= 1'b0;
                  dmem_req_reg    <= 1'b0;
                  mem_err_reg     <= 1'b1;
                  wb_valid_reg    <= 1'b1;
                  wb_rd_reg       <= rd_hold_reg;
                  wb_regwrite_reg <= 1'b0;
                  wb_data_reg     <= dmem_addr_reg;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
               stall_reg <= 1'b0;
            end
         endcase
      end
   end

   assign stall           = stall_reg;
   assign dmem.dmem_req   = dmem_req_reg;
   assign dmem.dmem_we    = dmem_we_reg;
   assign dmem.dmem_addr  = dmem_addr_reg;
   assign dmem.dmem_wdata = dmem_wdata_reg;
   assign wb_valid        = wb_valid_reg;
   assign wb_regwrite     = wb_regwrite_reg;
   assign wb_rd           = wb_rd_reg;
   assign wb_data         = wb_data_reg;
   assign pc_src          = pc_src_reg;
   assign pc_target       = pc_target_reg;
   assign mem_err         = mem_err_reg;

endmodule
